// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that turns set/clear commands into timed, non-overlapping S/R pulses.
// Build option SR_SKIP_REDUNDANT_EN: commands that would not change the shadow state skip the pulse.
//
// state   | meaning
// IDLE    | arbitrate among req, latch winner's command
// PULSE   | drive S or R of the latched flag for PULSE_CYC cycles
// RECOVER | guard cycle with no pulse, ack the winner
module sr_flag_arbiter #(
    parameter int NREQ      = 4,
    parameter int NFLAG     = 8,
    parameter int IDXW      = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0] idx,
    output logic [NREQ-1:0]      ack,
    output logic [NFLAG-1:0]     s_out,
    output logic [NFLAG-1:0]     r_out,
    output logic [NFLAG-1:0]     q,
    output logic                 busy,
    output logic                 err
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, PULSE, RECOVER} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     rr_ptr, rr_nxt;
    logic [PW-1:0]     win_id, win_id_nxt;
    logic              win_op, win_op_nxt;
    logic [NFLAG-1:0]  win_mask, win_mask_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [NFLAG-1:0]  s_nxt, r_nxt, q_nxt;
    logic [NREQ-1:0]   ack_nxt;
    logic              err_nxt;

    logic              gnt_valid;
    logic [PW-1:0]     gnt_id;
    logic [PW-1:0]     cand;
    logic [IDXW-1:0]   gnt_idx;
    logic              gnt_op;
    logic [NFLAG-1:0]  gnt_mask;
    logic              gnt_in_range;
    logic              gnt_skip;

    // first asserted request at or after rr_ptr, wrapping
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NREQ);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == PW'(i)) gnt_idx = idx[i*IDXW +: IDXW];
        end
    end

    assign gnt_op       = op[gnt_id];
    assign gnt_in_range = 32'(gnt_idx) < NFLAG;
    assign gnt_mask     = NFLAG'(1) << gnt_idx;

`ifdef SR_SKIP_REDUNDANT_EN
    assign gnt_skip = gnt_in_range && ((|(q & gnt_mask)) == gnt_op);
`else
    assign gnt_skip = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            win_id   <= '0;
            win_op   <= 1'b0;
            win_mask <= '0;
            cnt      <= '0;
            s_out    <= '0;
            r_out    <= '0;
            ack      <= '0;
            q        <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            win_id   <= win_id_nxt;
            win_op   <= win_op_nxt;
            win_mask <= win_mask_nxt;
            cnt      <= cnt_nxt;
            s_out    <= s_nxt;
            r_out    <= r_nxt;
            ack      <= ack_nxt;
            q        <= q_nxt;
            err      <= err_nxt;
        end
    end

    // outputs are computed one cycle ahead so s_out/r_out/ack/q come straight from flops
    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr_ptr;
        win_id_nxt   = win_id;
        win_op_nxt   = win_op;
        win_mask_nxt = win_mask;
        cnt_nxt      = cnt;
        s_nxt        = '0;
        r_nxt        = '0;
        ack_nxt      = '0;
        q_nxt        = q;
        err_nxt      = err;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    win_id_nxt   = gnt_id;
                    win_op_nxt   = gnt_op;
                    win_mask_nxt = gnt_mask;
                    rr_nxt       = PW'((int'(gnt_id) + 1) % NREQ);
                    if (!gnt_in_range) begin
                        err_nxt   = 1'b1;
                        ack_nxt   = NREQ'(1) << gnt_id;
                        state_nxt = RECOVER;
                    end else if (gnt_skip) begin
                        ack_nxt   = NREQ'(1) << gnt_id;
                        state_nxt = RECOVER;
                    end else begin
                        s_nxt     = gnt_op ? gnt_mask : '0;
                        r_nxt     = gnt_op ? '0 : gnt_mask;
                        cnt_nxt   = CW'(PULSE_CYC - 1);
                        state_nxt = PULSE;
                    end
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    q_nxt     = win_op ? (q | win_mask) : (q & ~win_mask);
                    ack_nxt   = NREQ'(1) << win_id;
                    state_nxt = RECOVER;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    s_nxt   = s_out;
                    r_nxt   = r_out;
                end
            end
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: an NFLAG=8 instance for the main flows and an
// NFLAG=6 instance for out-of-range index handling.
module tb_sr_flag_arbiter;
    localparam int PC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0, op = '0;
    logic [11:0] idx = '0;
    logic [3:0]  ack;
    logic [7:0]  s_out, r_out, q;
    logic        busy, err;

    logic [3:0]  req6 = '0, op6 = '0;
    logic [11:0] idx6 = '0;
    logic [3:0]  ack6;
    logic [5:0]  s6, r6, q6;
    logic        busy6, err6;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3), .PULSE_CYC(PC)) u_dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .ack(ack),
        .s_out(s_out), .r_out(r_out), .q(q), .busy(busy), .err(err)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3), .PULSE_CYC(PC)) u_dut6 (
        .clk(clk), .rst(rst), .req(req6), .op(op6), .idx(idx6), .ack(ack6),
        .s_out(s6), .r_out(r6), .q(q6), .busy(busy6), .err(err6)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req  = '0;
        req6 = '0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
    endtask

    // issue one command from requester id at the current (IDLE) cycle and follow it to completion
    task automatic do_single(input int id, input logic o, input logic [2:0] ix,
                             input logic [7:0] exp_q, input string tag);
        logic [7:0] m;
        m = 8'(1) << ix;
        req = '0;
        req[id] = 1'b1;
        op[id] = o;
        idx[id*3 +: 3] = ix;
        for (int c = 1; c <= PC; c++) begin
            tick();
            chk({tag, "_s"}, s_out, o ? m : 8'h00);
            chk({tag, "_r"}, r_out, o ? 8'h00 : m);
        end
        tick();
        chk({tag, "_ack"}, ack, 4'(1) << id);
        chk({tag, "_gap"}, s_out | r_out, 0);
        chk({tag, "_q"}, q, exp_q);
        req[id] = 1'b0;
        tick();
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_ack0"}, ack, 0);
    endtask

    initial begin
        int exp_id, run, nack, overlap, multi, badp, badrun, drain;
        logic [7:0] pl, em, q_model;
        logic [2:0] ix;

        // reset state
        tick();
        do_reset();
        chk("rst_s", s_out, 0);
        chk("rst_r", r_out, 0);
        chk("rst_q", q, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        // 1: single set of flag 3
        do_single(0, 1'b1, 3'd3, 8'h08, "t1");

        // 2: requesters 1 and 3 fight over flag 5
        do_reset();
        req = 4'b1010;
        op[1] = 1'b1; idx[3 +: 3] = 3'd5;
        op[3] = 1'b0; idx[9 +: 3] = 3'd5;
        tick(); chk("t2_s1", s_out, 8'h20); chk("t2_busy", busy, 1);
        tick(); chk("t2_s2", s_out, 8'h20);
        tick(); chk("t2_ack1", ack, 4'b0010); chk("t2_q1", q, 8'h20); chk("t2_gap1", s_out | r_out, 0);
        req[1] = 1'b0;
        tick(); chk("t2_idle", busy, 0); chk("t2_nopulse", s_out | r_out, 0);
        tick(); chk("t2_r1", r_out, 8'h20); chk("t2_s0", s_out, 0);
        tick(); chk("t2_r2", r_out, 8'h20);
        tick(); chk("t2_ack3", ack, 4'b1000); chk("t2_q2", q, 8'h00);
        req = '0;
        tick();
        // rr_ptr wrapped to 0: requester 0 must beat requester 3
        req = 4'b1001;
        op[0] = 1'b1; idx[0 +: 3] = 3'd0;
        op[3] = 1'b1; idx[9 +: 3] = 3'd1;
        tick(); chk("t2_wrap_s", s_out, 8'h01);
        tick();
        tick(); chk("t2_wrap_ack0", ack, 4'b0001);
        req[0] = 1'b0;
        tick();
        tick(); chk("t2_wrap_s3", s_out, 8'h02);
        tick();
        tick(); chk("t2_wrap_ack3", ack, 4'b1000); chk("t2_wrap_q", q, 8'h03);
        req = '0;
        tick();

        // 3: out-of-range index on the 6-flag instance
        req6 = 4'b0100; op6[2] = 1'b1; idx6[6 +: 3] = 3'd7;
        tick();
        chk("t3_ack", ack6, 4'b0100);
        chk("t3_nopulse", s6 | r6, 0);
        chk("t3_err", err6, 1);
        req6 = '0;
        tick(); chk("t3_idle", busy6, 0); chk("t3_ack0", ack6, 0); chk("t3_err_hold", err6, 1);
        req6 = 4'b0001; op6[0] = 1'b1; idx6[0 +: 3] = 3'd4;
        tick(); chk("t3_s", s6, 6'h10); chk("t3_err_sticky", err6, 1);
        tick();
        tick(); chk("t3_ack_ok", ack6, 4'b0001); chk("t3_q", q6, 6'h10);
        req6 = '0;
        tick(); chk("t3_err_end", err6, 1);

        // 4: reset lands in the second pulse cycle
        req = 4'b0001; op[0] = 1'b1; idx[0 +: 3] = 3'd2;
        tick(); chk("t4_s1", s_out, 8'h04);
        tick(); chk("t4_s2", s_out, 8'h04);
        rst = 1'b1; req = '0;
        tick();
        chk("t4_s", s_out, 0); chk("t4_r", r_out, 0); chk("t4_q", q, 0);
        chk("t4_ack", ack, 0); chk("t4_busy", busy, 0); chk("t4_err6", err6, 0);
        rst = 1'b0;
        tick(); chk("t4_noack", ack, 0);
        do_single(2, 1'b1, 3'd6, 8'h40, "t4_new");

        // 5: redundant set of flag 6
`ifdef SR_SKIP_REDUNDANT_EN
        req = 4'b0010; op[1] = 1'b1; idx[3 +: 3] = 3'd6;
        tick();
        chk("t5_ack", ack, 4'b0010);
        chk("t5_nopulse", s_out | r_out, 0);
        chk("t5_q", q, 8'h40);
        req = '0;
        tick(); chk("t5_idle", busy, 0);
`else
        do_single(1, 1'b1, 3'd6, 8'h40, "t5");
`endif

        // 6: all requesters held high with random commands
        do_reset();
        for (int i = 0; i < 4; i++) begin
            op[i] = 1'($urandom_range(0, 1));
            idx[i*3 +: 3] = 3'($urandom_range(0, 7));
        end
        req = 4'hF;
        exp_id = 0; run = 0; nack = 0; overlap = 0; multi = 0; badp = 0; badrun = 0;
        q_model = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            pl = s_out | r_out;
            if ((s_out & r_out) != 0) overlap++;
            if ($countones(pl) > 1) multi++;
            if (pl != 0) begin
                em = 8'(1) << idx[exp_id*3 +: 3];
                if (s_out != (op[exp_id] ? em : 8'h00) || r_out != (op[exp_id] ? 8'h00 : em)) badp++;
                run++;
            end else begin
                if (run != 0 && run != PC) badrun++;
                run = 0;
            end
            if (ack != 0) begin
                chk("t6_ack_order", ack, 4'(1) << exp_id);
                chk("t6_guard", pl, 0);
                ix = idx[exp_id*3 +: 3];
                q_model[ix] = op[exp_id];
                chk("t6_q", q, q_model);
                op[exp_id] = 1'($urandom_range(0, 1));
                idx[exp_id*3 +: 3] = 3'($urandom_range(0, 7));
                exp_id = (exp_id + 1) % 4;
                nack++;
            end
        end
        req = '0;
        drain = 0;
        while (busy && drain < 10) begin
            tick();
            drain++;
        end
        chk("t6_drain", busy, 0);
        chk("t6_overlap", overlap, 0);
        chk("t6_onehot", multi, 0);
        chk("t6_pulse_cmd", badp, 0);
        chk("t6_pulse_len", badrun, 0);
        chk("t6_nack", 32'(nack >= 10), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
